ef_gpio8_apb_arbiter: RTL and testbench

EF_GPIO8_APB_ARBITER -- requirements
Module: ef_gpio8_apb_arbiter

---
 rtl/ef_gpio8_apb_arbiter_if.sv | 20 ++
 rtl/ef_gpio8_apb_arbiter.sv | 117 +++++++++++
 tb/tb_ef_gpio8_apb_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ef_gpio8_apb_arbiter_if.sv
// rtl/ef_gpio8_apb_arbiter_if.sv - APB bus bundle between the arbiter (master) and the peripheral (slave)
interface ef_gpio8_apb_arbiter_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/ef_gpio8_apb_arbiter.sv
// rtl/ef_gpio8_apb_arbiter.sv - two-requester round-robin arbiter driving one APB master port
module ef_gpio8_apb_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          req0,
    input  logic                          we0,
    input  logic [15:0]                   addr0,
    input  logic [31:0]                   wdata0,
    output logic                          done0,
    output logic                          err0,
    input  logic                          req1,
    input  logic                          we1,
    input  logic [15:0]                   addr1,
    input  logic [31:0]                   wdata1,
    output logic                          done1,
    output logic                          err1,
    output logic [31:0]                   rdata,
    ef_gpio8_apb_arbiter_if.master        apb
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_last;
    logic        r_owner;
    logic [7:0]  r_wait;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic [31:0] r_rdata;
    logic        r_done0, r_done1, r_err0, r_err1;

    logic        w_grant;
    logic        w_winner;
    logic        w_we;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;

    // No arbitration in the done cycle: the finished requester is still dropping its request.
    assign w_grant  = (r_state == S_IDLE) && !r_done0 && !r_done1 && (req0 || req1);
    assign w_winner = (req0 && req1) ? ~r_last : req1;
    assign w_we     = w_winner ? we1    : we0;
    assign w_addr   = w_winner ? addr1  : addr0;
    assign w_wdata  = w_winner ? wdata1 : wdata0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_wait   <= 8'd0;
            r_paddr  <= 32'd0;
            r_pwdata <= 32'd0;
            r_pwrite <= 1'b0;
            r_rdata  <= 32'd0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_winner;
                        r_last   <= w_winner;
                        r_pwrite <= w_we;
                        r_paddr  <= {16'h0000, w_addr};
                        r_pwdata <= w_we ? w_wdata : 32'd0;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_wait  <= 8'd0;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (apb.PREADY) begin
                        r_state <= S_IDLE;
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        if (!r_pwrite) begin
                            r_rdata <= apb.PRDATA;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_state <= S_IDLE;
                        r_done0 <= ~r_owner;
                        r_done1 <= r_owner;
                        r_err0  <= ~r_owner;
                        r_err1  <= r_owner;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign apb.PSEL    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign apb.PENABLE = (r_state == S_ACCESS);
    assign apb.PADDR   = r_paddr;
    assign apb.PWDATA  = r_pwdata;
    assign apb.PWRITE  = r_pwrite;
    assign rdata       = r_rdata;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign err0        = r_err0;
    assign err1        = r_err1;
endmodule

// File: tb/tb_ef_gpio8_apb_arbiter.sv
// tb/tb_ef_gpio8_apb_arbiter.sv - randomized scoreboard bench for ef_gpio8_apb_arbiter
module tb_ef_gpio8_apb_arbiter;
    localparam int TO = 15;

    typedef struct {
        int          id;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        bit          b2b;
    } rec_t;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic        done0, err0, done1, err1;
    logic [31:0] rdata;

    ef_gpio8_apb_arbiter_if bus ();

    ef_gpio8_apb_arbiter #(.TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .err1(err1),
        .rdata(rdata), .apb(bus.master)
    );

    always #5 PCLK = ~PCLK;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    rec_t exp_q[$];
    bit   m_last = 1'b1;
    logic [31:0] m_rdata = 32'd0;
    int   setup_cyc = 0;
    int   last_done_cyc = 0;
    int   acc_cnt = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Peripheral: PREADY rises on the ACCESS cycle numbered by the record's wait count.
    initial begin
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'd0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE && exp_q.size() > 0) begin
                bus.PREADY = (acc_cnt == exp_q[0].waits);
                bus.PRDATA = bus.PREADY ? exp_q[0].prdata : $urandom;
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                bus.PREADY = 1'b0;
                bus.PRDATA = $urandom;
            end
        end
    end

    // Monitor: bus contents during transfers, and completion results against the queue.
    always @(negedge PCLK) begin
        rec_t r;
        bit   e;
        chk("done_err_excl", {29'd0, err0 & ~done0, err1 & ~done1, done0 & done1}, 32'd0);
        if (bus.PENABLE && !bus.PSEL) chk("penable_wo_psel", 32'd1, 32'd0);
        if (bus.PSEL) begin
            if (exp_q.size() == 0) begin
                chk("psel_unexpected", 32'd1, 32'd0);
            end else begin
                r = exp_q[0];
                chk("paddr", bus.PADDR, {16'h0, r.addr});
                chk("pwrite", {31'd0, bus.PWRITE}, {31'd0, r.we});
                chk("pwdata", bus.PWDATA, r.we ? r.wdata : 32'd0);
                if (!bus.PENABLE) begin
                    setup_cyc = cyc;
                    if (r.b2b) chk("b2b_gap", 32'(cyc - last_done_cyc), 32'd2);
                end
            end
        end
        if (done0 || done1) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                e = (r.waits >= TO);
                chk("done_id", {31'd0, done1}, 32'(r.id));
                chk("err", {30'd0, err1, err0}, e ? (r.id == 1 ? 32'd2 : 32'd1) : 32'd0);
                chk("xfer_len", 32'(cyc - setup_cyc), e ? 32'(TO + 1) : 32'(r.waits + 2));
                if (!r.we && !e) m_rdata = r.prdata;
                chk("rdata", rdata, m_rdata);
                chk("psel_in_done", {31'd0, bus.PSEL}, 32'd0);
                last_done_cyc = cyc;
            end
        end
    end

    function automatic rec_t mk(input int id, input logic we, input logic [15:0] a,
                                input logic [31:0] d, input logic [31:0] p, input int w, input bit b);
        rec_t r;
        r.id = id; r.we = we; r.addr = a; r.wdata = d; r.prdata = p; r.waits = w; r.b2b = b;
        return r;
    endfunction

    // mode 0/1: single requester, mode 2: both raise together.
    task automatic round(input int mode, input logic [1:0] we, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] p0,
                         input logic [31:0] p1, input int w0, input int w1);
        int first, second, n;
        we0 = we[0]; we1 = we[1]; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        if (mode == 2) begin
            first  = m_last ? 0 : 1;
            second = 1 - first;
            exp_q.push_back(mk(first, we[first], first ? a1 : a0, first ? d1 : d0,
                               first ? p1 : p0, first ? w1 : w0, 1'b0));
            exp_q.push_back(mk(second, we[second], second ? a1 : a0, second ? d1 : d0,
                               second ? p1 : p0, second ? w1 : w0, 1'b1));
            m_last = second[0];
            req0 = 1'b1; req1 = 1'b1;
        end else begin
            exp_q.push_back(mk(mode, we[mode], mode ? a1 : a0, mode ? d1 : d0,
                               mode ? p1 : p0, mode ? w1 : w0, 1'b0));
            m_last = mode[0];
            if (mode == 0) req0 = 1'b1; else req1 = 1'b1;
        end
        n = 0;
        while ((req0 || req1) && n < 200) begin
            @(negedge PCLK);
            n++;
            if (done0) req0 = 1'b0;
            if (done1) req1 = 1'b0;
            if (bus.PSEL && exp_q.size() > 0) begin
                if (exp_q[0].id == 0) begin addr0 = 16'($urandom); wdata0 = $urandom; end
                else                  begin addr1 = 16'($urandom); wdata1 = $urandom; end
            end
        end
        if (req0 || req1) begin
            chk("round_timeout", 32'd1, 32'd0);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    initial begin
        int wtab[7];
        int mode;
        wtab = '{0, 1, 2, 3, 14, 15, 20};
        #12;
        chk("rst_psel", {31'd0, bus.PSEL}, 32'd0);
        chk("rst_penable", {31'd0, bus.PENABLE}, 32'd0);
        chk("rst_outs", {26'd0, bus.PWRITE, done0, done1, err0, err1, 1'b0}, 32'd0);
        chk("rst_paddr", bus.PADDR, 32'd0);
        chk("rst_pwdata", bus.PWDATA, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        round(0, 2'b01, 16'h0004, 16'h0, 32'hA5, 32'h0, 32'h0, 32'h0, 0, 0);
        round(1, 2'b00, 16'h0, 16'h0000, 32'h0, 32'h0, 32'h0, 32'h3C, 0, 2);
        round(2, 2'b11, 16'h10, 16'h20, 32'h11, 32'h22, 32'h0, 32'h0, 0, 0);
        round(2, 2'b00, 16'h30, 16'h40, 32'h0, 32'h0, 32'h33, 32'h44, 0, 0);
        round(0, 2'b00, 16'h50, 16'h0, 32'h0, 32'h0, 32'hDEAD, 32'h0, 20, 0);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            round(mode, 2'($urandom), 16'($urandom), 16'($urandom), $urandom, $urandom,
                  $urandom, $urandom, wtab[$urandom_range(0, 6)], wtab[$urandom_range(0, 6)]);
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end

        // Reset in the middle of an ACCESS phase abandons the transfer silently.
        exp_q.push_back(mk(0, 1'b0, 16'h77, 32'h0, 32'h99, 20, 1'b0));
        we0 = 1'b0; addr0 = 16'h77; req0 = 1'b1;
        for (int k = 0; k < 20 && !bus.PENABLE; k++) @(negedge PCLK);
        chk("reached_access", {31'd0, bus.PENABLE}, 32'd1);
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        chk("arst_psel", {31'd0, bus.PSEL}, 32'd0);
        chk("arst_penable", {31'd0, bus.PENABLE}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        req0 = 1'b0;
        exp_q.delete();
        m_last = 1'b1;
        m_rdata = 32'd0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        round(2, 2'b01, 16'h0123, 16'h0456, 32'hCAFE, 32'hBEEF, 32'h0, 32'h5A5A, 1, 0);
        repeat (3) @(negedge PCLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
